// File: rtl/pwd_sender.sv
// Key-sequence transmitter for the password lock: drives a four-key code,
// waits for unlock, retries up to MAX_TRIES attempts, pulses done or fail.
module pwd_sender #(
    parameter logic [1:0]  K1        = 2'b10,
    parameter logic [1:0]  K2        = 2'b01,
    parameter logic [1:0]  K3        = 2'b10,
    parameter logic [1:0]  K4        = 2'b11,
    parameter logic [1:0]  IDLE_KEY  = 2'b00,
    parameter int unsigned TIMEOUT   = 4,
    parameter int unsigned MAX_TRIES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       unlock,
    output logic [1:0] key,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [3:0] tries
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT,
        FLUSH
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);
    localparam logic [3:0] TRY_MAX   = 4'(MAX_TRIES);

    state_t     state;
    logic [1:0] idx;
    logic [3:0] wcnt;

    function automatic logic [1:0] code_key(input logic [1:0] i);
        case (i)
            2'd0:    code_key = K1;
            2'd1:    code_key = K2;
            2'd2:    code_key = K3;
            default: code_key = K4;
        endcase
    endfunction

    // NOTE: every register here is written with <= so all of them update from
    // the same pre-edge values; mixing in = would make order inside the block matter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            key   <= IDLE_KEY;
            busy  <= 1'b0;
            done  <= 1'b0;
            fail  <= 1'b0;
            tries <= 4'd0;
            idx   <= 2'd0;
            wcnt  <= 4'd0;
        end else begin
            // Pulses default low so each is high for a single cycle only.
            done <= 1'b0;
            fail <= 1'b0;
            if (abort) begin
                state <= IDLE;
                key   <= IDLE_KEY;
                busy  <= 1'b0;
                idx   <= 2'd0;
                wcnt  <= 4'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && unlock) begin
                            done  <= 1'b1;
                            tries <= 4'd0;
                        end else if (start) begin
                            state <= SEND;
                            idx   <= 2'd0;
                            key   <= K1;
                            busy  <= 1'b1;
                            tries <= 4'd1;
                        end
                    end
                    SEND: begin
                        if (idx == 2'd3) begin
                            state <= WAIT;
                            key   <= IDLE_KEY;
                            wcnt  <= 4'd0;
                        end else begin
                            idx <= idx + 2'd1;
                            key <= code_key(idx + 2'd1);
                        end
                    end
                    WAIT: begin
                        if (unlock) begin
                            done  <= 1'b1;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else if (wcnt == WAIT_LAST) begin
                            if (tries >= TRY_MAX) begin
                                fail  <= 1'b1;
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state <= FLUSH;
                            end
                        end else begin
                            wcnt <= wcnt + 4'd1;
                        end
                    end
                    FLUSH: begin
                        // One idle-key cycle lets the lock's match counter clear.
                        state <= SEND;
                        idx   <= 2'd0;
                        key   <= K1;
                        if (tries < TRY_MAX) tries <= tries + 4'd1;
                    end
                    default: begin
                        state <= IDLE;
                        key   <= IDLE_KEY;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwd_sender.sv
// Table-driven bench for pwd_sender: per-cycle vectors with a scoreboard of
// expected outputs, plus hand-written reset-during-WAIT sequence.
module tb_pwd_sender;

    localparam logic [1:0] K1        = 2'b10;
    localparam logic [1:0] K2        = 2'b01;
    localparam logic [1:0] K3        = 2'b10;
    localparam logic [1:0] K4        = 2'b11;
    localparam logic [1:0] IK        = 2'b00;
    localparam int         TIMEOUT   = 4;
    localparam int         MAX_TRIES = 3;

    typedef struct {
        logic       start;
        logic       abort;
        logic       unlock;
        logic [1:0] key;
        logic       busy;
        logic       done;
        logic       fail;
        logic [3:0] tries;
    } vec_t;

    typedef struct {
        logic [1:0] key;
        logic       busy;
        logic       done;
        logic       fail;
        logic [3:0] tries;
        int         row;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, abort, unlock;
    logic [1:0] key;
    logic       busy, done, fail;
    logic [3:0] tries;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[$];
    exp_t exp_q[$];

    pwd_sender dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .abort  (abort),
        .unlock (unlock),
        .key    (key),
        .busy   (busy),
        .done   (done),
        .fail   (fail),
        .tries  (tries)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %0h expected %0h (t=%0t)", name, row, act, exp, $time);
        end
    endtask

    function automatic void add(input logic st, input logic ab, input logic ul, input logic [1:0] k,
                                input logic b, input logic d, input logic f, input int t);
        vec_t v;
        v.start = st; v.abort = ab; v.unlock = ul;
        v.key = k; v.busy = b; v.done = d; v.fail = f; v.tries = 4'(t);
        vecs.push_back(v);
    endfunction

    // Drive one cycle of inputs, record what must appear after the edge, compare.
    task automatic apply(input vec_t v, input int row);
        exp_t e;
        @(negedge clk);
        start  = v.start;
        abort  = v.abort;
        unlock = v.unlock;
        e.key = v.key; e.busy = v.busy; e.done = v.done; e.fail = v.fail;
        e.tries = v.tries; e.row = row;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("key",   e.row, 32'(key),   32'(e.key));
        check("busy",  e.row, 32'(busy),  32'(e.busy));
        check("done",  e.row, 32'(done),  32'(e.done));
        check("fail",  e.row, 32'(fail),  32'(e.fail));
        check("tries", e.row, 32'(tries), 32'(e.tries));
    endtask

    task automatic run_table();
        foreach (vecs[i]) apply(vecs[i], i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; unlock = 1'b0;
        #1 rst = 1'b0;
        #11;
        check("reset_key",   -1, 32'(key),   32'(IK));
        check("reset_busy",  -1, 32'(busy),  0);
        check("reset_done",  -1, 32'(done),  0);
        check("reset_fail",  -1, 32'(fail),  0);
        check("reset_tries", -1, 32'(tries), 0);
        @(negedge clk);
        rst = 1'b1;

        // Lock never unlocks: three bursts, each followed by WAIT and FLUSH/fail.
        for (int a = 1; a <= MAX_TRIES; a++) begin
            add(a == 1, 0, 0, K1, 1, 0, 0, a);
            add(0, 0, 0, K2, 1, 0, 0, a);
            add(0, 0, 0, K3, 1, 0, 0, a);
            add(0, 0, 0, K4, 1, 0, 0, a);
            for (int w = 0; w < TIMEOUT; w++) add(0, 0, 0, IK, 1, 0, 0, a);
            if (a < MAX_TRIES) add(0, 0, 0, IK, 1, 0, 0, a);
            else               add(0, 0, 0, IK, 0, 0, 1, a);
        end
        add(0, 0, 0, IK, 0, 0, 0, MAX_TRIES);

        // Matched lock: unlock in the cycle after K4 is sampled.
        add(1, 0, 0, K1, 1, 0, 0, 1);
        add(0, 0, 0, K2, 1, 0, 0, 1);
        add(0, 0, 0, K3, 1, 0, 0, 1);
        add(0, 0, 0, K4, 1, 0, 0, 1);
        add(0, 0, 0, IK, 1, 0, 0, 1);
        add(0, 0, 1, IK, 0, 1, 0, 1);
        add(0, 0, 0, IK, 0, 0, 0, 1);

        // Unlock already high when start is sampled.
        add(1, 0, 1, IK, 0, 1, 0, 0);
        add(0, 0, 0, IK, 0, 0, 0, 0);

        // Abort while K2 is on the bus, then a full successful send.
        add(1, 0, 0, K1, 1, 0, 0, 1);
        add(0, 0, 0, K2, 1, 0, 0, 1);
        add(0, 1, 0, IK, 0, 0, 0, 1);
        add(0, 0, 0, IK, 0, 0, 0, 1);
        add(1, 0, 0, K1, 1, 0, 0, 1);
        add(0, 0, 0, K2, 1, 0, 0, 1);
        add(0, 0, 0, K3, 1, 0, 0, 1);
        add(0, 0, 0, K4, 1, 0, 0, 1);
        add(0, 0, 0, IK, 1, 0, 0, 1);
        add(0, 0, 1, IK, 0, 1, 0, 1);
        add(0, 0, 0, IK, 0, 0, 0, 1);

        // Abort in WAIT wins over a simultaneous unlock.
        add(1, 0, 0, K1, 1, 0, 0, 1);
        add(0, 0, 0, K2, 1, 0, 0, 1);
        add(0, 0, 0, K3, 1, 0, 0, 1);
        add(0, 0, 0, K4, 1, 0, 0, 1);
        add(0, 0, 0, IK, 1, 0, 0, 1);
        add(0, 1, 1, IK, 0, 0, 0, 1);
        add(0, 0, 0, IK, 0, 0, 0, 1);

        // Start held for 10 cycles: one full operation, then a restart on the first IDLE cycle.
        add(1, 0, 0, K1, 1, 0, 0, 1);
        add(1, 0, 0, K2, 1, 0, 0, 1);
        add(1, 0, 0, K3, 1, 0, 0, 1);
        add(1, 0, 0, K4, 1, 0, 0, 1);
        add(1, 0, 0, IK, 1, 0, 0, 1);
        add(1, 0, 1, IK, 0, 1, 0, 1);
        add(1, 0, 0, K1, 1, 0, 0, 1);
        add(1, 0, 0, K2, 1, 0, 0, 1);
        add(1, 0, 0, K3, 1, 0, 0, 1);
        add(1, 0, 0, K4, 1, 0, 0, 1);
        add(0, 0, 0, IK, 1, 0, 0, 1);
        add(0, 0, 1, IK, 0, 1, 0, 1);
        add(0, 0, 0, IK, 0, 0, 0, 1);

        // Bring the sender into WAIT ahead of the asynchronous reset.
        add(1, 0, 0, K1, 1, 0, 0, 1);
        add(0, 0, 0, K2, 1, 0, 0, 1);
        add(0, 0, 0, K3, 1, 0, 0, 1);
        add(0, 0, 0, K4, 1, 0, 0, 1);
        add(0, 0, 0, IK, 1, 0, 0, 1);
        add(0, 0, 0, IK, 1, 0, 0, 1);

        run_table();

        // Reset mid-WAIT takes effect between clock edges.
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst_key",   -2, 32'(key),   32'(IK));
        check("async_rst_busy",  -2, 32'(busy),  0);
        check("async_rst_tries", -2, 32'(tries), 0);
        check("async_rst_done",  -2, 32'(done),  0);
        check("async_rst_fail",  -2, 32'(fail),  0);
        @(negedge clk);
        rst = 1'b1;
        vecs.delete();
        add(0, 0, 1, IK, 0, 0, 0, 0);
        for (int i = 0; i < TIMEOUT + 2; i++) add(0, 0, 0, IK, 0, 0, 0, 0);
        run_table();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
